// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the fixed-point serial arithmetic blocks (multiplier, divider).
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2,
        ST_ILL  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 64;

    // Bits needed for an iteration counter running 0..w-1.
    function automatic int cnt_w(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_mult_dp.sv
// Shift-and-add datapath: operand registers plus a 2w accumulator that retires one multiplier bit per step.
// load strobes capture operands, clr zeroes acc, step performs one add-and-shift; acc_step is the next acc value.
module serial_mult_dp #(
    parameter int width = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     x,
    input  logic [width-1:0]     y,
    input  logic                 ld_x,
    input  logic                 ld_y,
    input  logic                 clr,
    input  logic                 step,
    output logic [2*width-1:0]   acc_step
);

    logic [width-1:0]   mcand_q, mcand_d;
    logic [width-1:0]   mplier_q, mplier_d;
    logic [2*width-1:0] acc_q, acc_d;
    logic [width:0]     sum;

    always_comb begin
        // w+1-bit sum keeps the carry, which lands in the top bit of acc after the shift.
        sum      = {1'b0, acc_q[2*width-1:width]} + {1'b0, (mplier_q[0] ? mcand_q : {width{1'b0}})};
        acc_step = {sum, acc_q[width-1:1]};

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (ld_x) begin
            mcand_d = x;
        end
        if (ld_y) begin
            mplier_d = y;
        end
        if (clr) begin
            acc_d = '0;
        end
        if (step) begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/serial_mult.sv
// Bit-serial unsigned multiplier: x and y on independent valid/ready inputs, 2w product on a valid/ready output.
// Result valid width+1 cycles after the last operand is captured; holds in DONE while d_out_rdy is low.
module serial_mult
    import serial_arith_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic [width-1:0]     x,
    input  logic                 data_x_vld,
    output logic                 data_x_rdy,
    input  logic [width-1:0]     y,
    input  logic                 data_y_vld,
    output logic                 data_y_rdy,
    output logic [2*width-1:0]   product,
    output logic                 d_out_vld,
    input  logic                 d_out_rdy
);

    localparam int            CW       = cnt_w(width);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    state_t             state_q, state_d;
    logic               have_x_q, have_x_d;
    logic               have_y_q, have_y_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*width-1:0] product_q, product_d;

    logic               x_fire, y_fire;
    logic               nx, ny;
    logic               clr, step;
    logic [2*width-1:0] acc_step;

    // Handshake outputs decode from state/flags only; reset forces them low.
    assign data_x_rdy = !asyn_reset && (state_q == ST_LOAD) && !have_x_q;
    assign data_y_rdy = !asyn_reset && (state_q == ST_LOAD) && !have_y_q;
    assign d_out_vld  = !asyn_reset && (state_q == ST_DONE);
    assign product    = product_q;

    always_comb begin
        x_fire    = data_x_vld && data_x_rdy;
        y_fire    = data_y_vld && data_y_rdy;
        nx        = have_x_q || x_fire;
        ny        = have_y_q || y_fire;
        state_d   = state_q;
        have_x_d  = have_x_q;
        have_y_d  = have_y_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        clr       = 1'b0;
        step      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (nx && ny) begin
                    state_d  = ST_COMP;
                    have_x_d = 1'b0;
                    have_y_d = 1'b0;
                    cnt_d    = '0;
                    clr      = 1'b1;
                end else begin
                    have_x_d = nx;
                    have_y_d = ny;
                end
            end
            ST_COMP: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_step;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (d_out_rdy) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q   <= ST_LOAD;
            have_x_q  <= 1'b0;
            have_y_q  <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            have_x_q  <= have_x_d;
            have_y_q  <= have_y_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    serial_mult_dp #(
        .width (width)
    ) u_dp (
        .clk      (clk),
        .rst      (asyn_reset),
        .x        (x),
        .y        (y),
        .ld_x     (x_fire),
        .ld_y     (y_fire),
        .clr      (clr),
        .step     (step),
        .acc_step (acc_step)
    );

endmodule

// File: tb/tb_serial_mult.sv
// Directed vectors on an 8-bit instance plus a randomized stream on a 64-bit instance.
module tb_serial_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]   x8, y8;
    logic         xv8, yv8, xr8, yr8, ov8, or8;
    logic [15:0]  p8;

    logic [63:0]  x64, y64;
    logic         xv64, yv64, xr64, yr64, ov64, or64;
    logic [127:0] p64;

    int checks = 0;
    int errors = 0;

    serial_mult #(.width(8)) dut8 (
        .clk        (clk),
        .asyn_reset (rst),
        .x          (x8),
        .data_x_vld (xv8),
        .data_x_rdy (xr8),
        .y          (y8),
        .data_y_vld (yv8),
        .data_y_rdy (yr8),
        .product    (p8),
        .d_out_vld  (ov8),
        .d_out_rdy  (or8)
    );

    serial_mult #(.width(64)) dut64 (
        .clk        (clk),
        .asyn_reset (rst),
        .x          (x64),
        .data_x_vld (xv64),
        .data_x_rdy (xr64),
        .y          (y64),
        .data_y_vld (yv64),
        .data_y_rdy (yr64),
        .product    (p64),
        .d_out_vld  (ov64),
        .d_out_rdy  (or64)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Polls at negedges until d_out_vld; n counts cycles, the cycle after the capture edge being 1.
    task automatic wait_vld8(output int n);
        n = 1;
        while (!ov8 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Both operands in one cycle (cycle 0); the result must appear in cycle 9 and last one cycle.
    task automatic do_pair(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input string name);
        int n;
        @(negedge clk);
        x8 = a; y8 = b; xv8 = 1'b1; yv8 = 1'b1; or8 = 1'b1;
        chk({name, " x_rdy"}, xr8, 1);
        chk({name, " y_rdy"}, yr8, 1);
        @(negedge clk);
        xv8 = 1'b0; yv8 = 1'b0;
        wait_vld8(n);
        chk({name, " latency"}, n, 9);
        chk({name, " product"}, p8, p);
        @(negedge clk);
        chk({name, " vld one cycle"}, ov8, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        string       name;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] xs[200];
    logic [63:0] ys[200];

    initial begin
        int  n;
        bit  flag;

        vecs[0] = '{8'd13,  8'd11,  16'd143,   "13x11"};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, "255x255"};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     "0x200"};
        vecs[3] = '{8'd128, 8'd2,   16'd256,   "128x2"};
        vecs[4] = '{8'd1,   8'd255, 16'd255,   "1x255"};
        vecs[5] = '{8'd170, 8'd85,  16'd14450, "170x85"};

        x8 = '0; y8 = '0; xv8 = 1'b0; yv8 = 1'b0; or8 = 1'b0;
        x64 = '0; y64 = '0; xv64 = 1'b0; yv64 = 1'b0; or64 = 1'b0;
        rst = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset x_rdy forced low", xr8, 0);
        chk("reset y_rdy forced low", yr8, 0);
        chk("reset vld low", ov8, 0);
        rst = 1'b0;
        #1;
        chk("post-reset x_rdy", xr8, 1);
        chk("post-reset y_rdy", yr8, 1);
        chk("post-reset vld", ov8, 0);
        chk("post-reset product8", p8, 0);
        chk("post-reset product64", p64, 0);

        for (int i = 0; i < 6; i++) begin
            do_pair(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
        end

        // x alone, y five cycles later
        @(negedge clk);
        x8 = 8'd7; xv8 = 1'b1; or8 = 1'b1;
        chk("split x_rdy before", xr8, 1);
        @(negedge clk);
        xv8 = 1'b0;
        chk("split x_rdy after x", xr8, 0);
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!yr8 || xr8) flag = 1'b0;
            @(negedge clk);
        end
        chk("split y_rdy held while waiting", flag, 1);
        y8 = 8'd6; yv8 = 1'b1;
        chk("split y_rdy at y", yr8, 1);
        @(negedge clk);
        yv8 = 1'b0;
        wait_vld8(n);
        chk("split product", p8, 42);
        @(negedge clk);

        // DONE stall with operands pending
        x8 = 8'd9; y8 = 8'd9; xv8 = 1'b1; yv8 = 1'b1; or8 = 1'b0;
        @(negedge clk);
        xv8 = 1'b0; yv8 = 1'b0;
        wait_vld8(n);
        chk("stall first product", p8, 81);
        x8 = 8'd1; y8 = 8'd1; xv8 = 1'b1; yv8 = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!ov8 || p8 != 16'd81 || xr8 || yr8) flag = 1'b0;
        end
        chk("stall outputs stable", flag, 1);
        or8 = 1'b1; xv8 = 1'b0; yv8 = 1'b0;
        @(negedge clk);
        chk("stall released vld", ov8, 0);
        chk("stall released x_rdy", xr8, 1);

        // reset during the 4th COMP cycle
        x8 = 8'd200; y8 = 8'd100; xv8 = 1'b1; yv8 = 1'b1;
        @(negedge clk);
        xv8 = 1'b0; yv8 = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ov8) flag = 1'b1;
        end
        rst = 1'b1;
        #1;
        chk("mid-comp reset rdy forced low", {xr8, yr8}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid-comp reset x_rdy", xr8, 1);
        chk("mid-comp reset y_rdy", yr8, 1);
        chk("mid-comp reset product", p8, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ov8) flag = 1'b1;
        end
        chk("mid-comp reset no vld pulse", flag, 0);
        do_pair(8'd3, 8'd5, 16'd15, "3x5 after reset");

        // 64-bit randomized stream
        for (int i = 0; i < 200; i++) begin
            xs[i] = {$urandom, $urandom};
            ys[i] = {$urandom, $urandom};
        end
        xs[0] = '1; ys[0] = '1;
        xs[1] = '0;
        ys[2] = 64'd1;

        fork
            begin
                int w;
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    x64 = xs[i]; xv64 = 1'b1;
                    w = 0;
                    while (!xr64 && w < 500) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!xr64) begin
                        chk("stream x accept timeout", 0, 1);
                        xv64 = 1'b0;
                        break;
                    end
                    @(negedge clk);
                    xv64 = 1'b0;
                end
            end
            begin
                int w;
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    y64 = ys[i]; yv64 = 1'b1;
                    w = 0;
                    while (!yr64 && w < 500) begin
                        @(negedge clk);
                        w++;
                    end
                    if (!yr64) begin
                        chk("stream y accept timeout", 0, 1);
                        yv64 = 1'b0;
                        break;
                    end
                    @(negedge clk);
                    yv64 = 1'b0;
                end
            end
            begin
                int recv;
                int cyc;
                logic [127:0] ref_p;
                recv = 0;
                cyc  = 0;
                while (recv < 200 && cyc < 30000) begin
                    @(negedge clk);
                    cyc++;
                    or64 = ($urandom_range(0, 3) != 0);
                    if (ov64 && or64) begin
                        ref_p = {64'd0, xs[recv]} * {64'd0, ys[recv]};
                        chk("stream product", p64, ref_p);
                        recv++;
                    end
                end
                chk("stream result count", recv, 200);
                or64 = 1'b0;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
